rtc_timekeeper: RTL and testbench
=================================

# rtc_timekeeper

Parametrised real-time clock core that keeps hours, minutes, seconds and sub-second ticks from the kh_clk domain. It adds run/hold control, a validated time-load handshake, one-shot daylight-saving hour adjustment, a 12/24-hour display mode and rollover strobes. It sits between the kilohertz clock divider and the display/alarm logic, and it drives the packed display time word.

## Interface
- TICKS_PER_SEC, default 1000: kh_clk cycles per second (≥2).
- SUB_W, default 10: width of sub-second counter; must satisfy 2^SUB_W ≥ TICKS_PER_SEC.

- kh_clk  in  1  timebase clock, one tick per cycle when running.
- reset  in  1  asynchronous, active-high; clock kh_clk.
- run_en  in  1  1 = advance time each cycle; 0 = hold all counters.
- mode_12h  in  1  display format select; 0 = 24 h, 1 = 12 h.
- set_valid  in  1  time-load request, sampled each cycle.
- set_hr / set_min / set_sec  in  5/6/6  time to load (24 h format).
- set_ack  out  1  one-cycle pulse: load accepted.
- set_err  out  1  one-cycle pulse: load rejected (out of range).
- dst_fwd / dst_back  in  1  one-cycle requests: hour +1 / hour −1.
- hr  out  5  internal hour, 0..23.
- min, sec  out  6  0..59.
- sub  out  SUB_W  0..TICKS_PER_SEC−1.
- disp_hr  out  5  0..23 in 24 h mode; 1..12 in 12 h mode.
- pm  out  1  1 when hr ≥ 12, in either mode.
- sec_pulse, min_pulse, day_pulse  out  1  rollover strobes.
- disp_time  out  17+SUB_W  {disp_hr, min, sec, sub}.

## Operation
- All outputs are registered. Reset value: hr = min = sec = sub = 0, disp_hr = 0 (24 h) or 12 (12 h), pm = 0, and all pulses = 0.
- Increment (run_en = 1, no load): sub +1. At sub = TICKS_PER_SEC−1, sub → 0 and sec +1. At sec = 59, sec → 0 and min +1. At min = 59, min → 0 and hr +1. At hr = 23, hr → 0.
- run_en = 0: counters hold. Loads and DST adjustments still apply.
- Time load: when set_valid = 1, the block checks set_hr ≤ 23, set_min ≤ 59 and set_sec ≤ 59.
  - Valid: next cycle, hr/min/sec take the set values, sub = 0, and set_ack = 1.
  - Invalid: time advances normally and set_err = 1.
  - set_valid held high is evaluated every cycle.
- DST: dst_fwd adds 1 to the hour and dst_back subtracts 1. Both use mod-24 wrap (23 → 0, 0 → 23). Minutes, seconds and sub are unaffected.
  - The adjustment applies to the hour produced by the same cycle's increment.
  - dst_fwd and dst_back together cancel; no change.
- Priority in a cycle: reset > valid load > (increment, then DST). A valid load discards same-cycle DST requests and increment. A rejected load does not block DST or increment.
- 12 h display: hr 0 → disp_hr 12, pm 0; hr 1..11 → disp_hr = hr, pm 0; hr 12 → disp_hr 12, pm 1; hr 13..23 → disp_hr = hr−12, pm 1. mode_12h changes affect only disp_hr and disp_time.
- Pulses come only from natural increment carries:
  - sec_pulse on a sub wrap.
  - min_pulse on a sec wrap.
  - day_pulse on the 23:59:59 → 00:00:00.0 wrap.
  - Loads and DST never produce pulses, including a DST wrap across midnight.
- Reset asserted mid-operation clears everything asynchronously. Counting resumes on the first kh_clk edge after reset deasserts.

## Timing
- Latency is one kh_clk cycle from an input (set_valid, dst_*, run_en, mode_12h) to every output.
- hr, min, sec, sub, disp_hr, pm, disp_time and pulses update on the same edge and are mutually consistent.
- A pulse is high in exactly the cycle in which the outputs first show the new value (for example, sec_pulse high with sub = 0).
- set_ack and set_err are mutually exclusive and last one cycle per request cycle.
- With run_en = 1 continuously, exactly one second elapses per TICKS_PER_SEC cycles. One full day takes 86400·TICKS_PER_SEC cycles.

## Test plan
- Reset, then run with TICKS_PER_SEC = 4 for 4 cycles -> sub goes 1,2,3,0, sec = 1, and sec_pulse is high only on the 4th cycle.
- Load 23:59:59 and run 4 cycles -> output 00:00:00.0; sec_pulse, min_pulse and day_pulse are high together for one cycle.
- set_valid with 24:00:00 -> set_err = 1 and time keeps counting. Then set 12:30:45 -> set_ack = 1, time = 12:30:45.0, and no pulses.
- At hr = 23, pulse dst_fwd -> hr = 0 with no day_pulse. At hr = 0, pulse dst_back -> hr = 23. dst_fwd and dst_back together -> hr unchanged.
- mode_12h = 1 with loaded hours 0, 11, 12 and 13 -> disp_hr/pm = 12/0, 11/0, 12/1 and 1/1 respectively, while hr stays 24 h.
- Assert reset mid-count at 05:17:33.2, not on a clock edge -> all outputs go to 0 immediately. After deassertion and one cycle, sub = 1.

Source files
------------

// File: rtl/rtc_timekeeper_if.sv
// rtc_timekeeper_if
// Bundles the control, time-load, DST and display signals of the real-time
// clock core. The clock and reset are not part of the bundle.
//   master : the controller side (drives run/mode/load/DST requests, reads time)
//   slave  : the rtc_timekeeper core
// Signals:
//   run_en, mode_12h, set_valid, set_hr/min/sec, dst_fwd, dst_back : master -> slave
//   set_ack, set_err, hr, min, sec, sub, disp_hr, pm,
//   sec_pulse, min_pulse, day_pulse, disp_time                     : slave -> master
interface rtc_timekeeper_if #(
  parameter int SUB_W = 10
);
  logic             run_en;
  logic             mode_12h;
  logic             set_valid;
  logic [4:0]       set_hr;
  logic [5:0]       set_min;
  logic [5:0]       set_sec;
  logic             set_ack;
  logic             set_err;
  logic             dst_fwd;
  logic             dst_back;
  logic [4:0]       hr;
  logic [5:0]       min;
  logic [5:0]       sec;
  logic [SUB_W-1:0] sub;
  logic [4:0]       disp_hr;
  logic             pm;
  logic             sec_pulse;
  logic             min_pulse;
  logic             day_pulse;
  logic [16+SUB_W:0] disp_time;

  modport master (
    output run_en, mode_12h, set_valid, set_hr, set_min, set_sec, dst_fwd, dst_back,
    input  set_ack, set_err, hr, min, sec, sub, disp_hr, pm,
           sec_pulse, min_pulse, day_pulse, disp_time
  );

  modport slave (
    input  run_en, mode_12h, set_valid, set_hr, set_min, set_sec, dst_fwd, dst_back,
    output set_ack, set_err, hr, min, sec, sub, disp_hr, pm,
           sec_pulse, min_pulse, day_pulse, disp_time
  );
endinterface

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper
// Real-time clock core counting hours/minutes/seconds/sub-second ticks in the
// kh_clk domain, with run/hold, validated time load, one-shot DST hour
// adjustment, 12/24 h display decode and rollover strobes.
// Ports:
//   kh_clk  : timebase clock, one tick per cycle while running
//   reset   : asynchronous, active-high, clears all time state and strobes
//   bus     : rtc_timekeeper_if.slave (control inputs, time/display outputs)
// Parameters:
//   TICKS_PER_SEC : kh_clk cycles per second (>= 2)
//   SUB_W         : sub-second counter width, 2**SUB_W >= TICKS_PER_SEC
module rtc_timekeeper #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int SUB_W         = 10
) (
  input logic             kh_clk,
  input logic             reset,
  rtc_timekeeper_if.slave bus
);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);

  // Hour arithmetic wraps modulo 24.
  function automatic logic [4:0] hr_add1(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [4:0] hr_sub1(input logic [4:0] h);
    return (h == 5'd0) ? 5'd23 : h - 5'd1;
  endfunction

  // 12 h display maps 0 -> 12 and 13..23 -> 1..11.
  function automatic logic [4:0] disp_hour(input logic [4:0] h, input logic m12);
    logic [4:0] d;
    d = h;
    if (m12) begin
      if (h == 5'd0)      d = 5'd12;
      else if (h > 5'd12) d = h - 5'd12;
    end
    return d;
  endfunction

  logic [4:0]       hr_p0;
  logic [5:0]       min_p0;
  logic [5:0]       sec_p0;
  logic [SUB_W-1:0] sub_p0;
  logic             sec_pulse_p0, min_pulse_p0, day_pulse_p0;
  logic             set_ack_p0, set_err_p0;
  logic             mode_p0;

  logic [4:0]       hr_nxt, hr_inc;
  logic [5:0]       min_nxt, sec_nxt;
  logic [SUB_W-1:0] sub_nxt;
  logic             sub_wrap, sec_wrap, min_wrap, day_wrap, load_ok;
  logic             sec_pulse_nxt, min_pulse_nxt, day_pulse_nxt;
  logic             set_ack_nxt, set_err_nxt;

  always_comb begin
    // Carry chain of the natural increment; everything collapses when held.
    sub_wrap = bus.run_en && (sub_p0 == SUB_LAST);
    sec_wrap = sub_wrap && (sec_p0 == 6'd59);
    min_wrap = sec_wrap && (min_p0 == 6'd59);
    day_wrap = min_wrap && (hr_p0 == 5'd23);
    load_ok  = bus.set_valid && (bus.set_hr <= 5'd23) &&
               (bus.set_min <= 6'd59) && (bus.set_sec <= 6'd59);
    hr_inc   = min_wrap ? hr_add1(hr_p0) : hr_p0;

    hr_nxt        = hr_p0;
    min_nxt       = min_p0;
    sec_nxt       = sec_p0;
    sub_nxt       = sub_p0;
    sec_pulse_nxt = 1'b0;
    min_pulse_nxt = 1'b0;
    day_pulse_nxt = 1'b0;
    set_ack_nxt   = 1'b0;
    set_err_nxt   = bus.set_valid && !load_ok;

    if (load_ok) begin
      // An accepted load overrides increment and DST in the same cycle.
      hr_nxt      = bus.set_hr;
      min_nxt     = bus.set_min;
      sec_nxt     = bus.set_sec;
      sub_nxt     = '0;
      set_ack_nxt = 1'b1;
    end else begin
      if (bus.run_en) sub_nxt = sub_wrap ? '0 : sub_p0 + SUB_ONE;
      if (sub_wrap)   sec_nxt = sec_wrap ? 6'd0 : sec_p0 + 6'd1;
      if (sec_wrap)   min_nxt = min_wrap ? 6'd0 : min_p0 + 6'd1;
      // DST acts on the already-incremented hour; both requests cancel.
      hr_nxt = hr_inc;
      if (bus.dst_fwd && !bus.dst_back)      hr_nxt = hr_add1(hr_inc);
      else if (bus.dst_back && !bus.dst_fwd) hr_nxt = hr_sub1(hr_inc);
      sec_pulse_nxt = sub_wrap;
      min_pulse_nxt = sec_wrap;
      day_pulse_nxt = day_wrap;
    end
  end

  // Stage p0: time state, strobes and handshake responses
  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      hr_p0        <= '0;
      min_p0       <= '0;
      sec_p0       <= '0;
      sub_p0       <= '0;
      sec_pulse_p0 <= 1'b0;
      min_pulse_p0 <= 1'b0;
      day_pulse_p0 <= 1'b0;
      set_ack_p0   <= 1'b0;
      set_err_p0   <= 1'b0;
    end else begin
      hr_p0        <= hr_nxt;
      min_p0       <= min_nxt;
      sec_p0       <= sec_nxt;
      sub_p0       <= sub_nxt;
      sec_pulse_p0 <= sec_pulse_nxt;
      min_pulse_p0 <= min_pulse_nxt;
      day_pulse_p0 <= day_pulse_nxt;
      set_ack_p0   <= set_ack_nxt;
      set_err_p0   <= set_err_nxt;
    end
  end

  // Display mode is sampled even during reset so the reset-time display
  // already reflects the selected format (hour 0 shows as 12 in 12 h mode).
  always_ff @(posedge kh_clk) begin
    mode_p0 <= bus.mode_12h;
  end

  assign bus.hr        = hr_p0;
  assign bus.min       = min_p0;
  assign bus.sec       = sec_p0;
  assign bus.sub       = sub_p0;
  assign bus.disp_hr   = disp_hour(hr_p0, mode_p0);
  assign bus.pm        = (hr_p0 >= 5'd12);
  assign bus.disp_time = {disp_hour(hr_p0, mode_p0), min_p0, sec_p0, sub_p0};
  assign bus.sec_pulse = sec_pulse_p0;
  assign bus.min_pulse = min_pulse_p0;
  assign bus.day_pulse = day_pulse_p0;
  assign bus.set_ack   = set_ack_p0;
  assign bus.set_err   = set_err_p0;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper
// Directed bench for rtc_timekeeper with TICKS_PER_SEC = 4. The driver pushes
// the hand-computed expected state for each cycle into a queue; a monitor
// pops one entry after each active edge and compares it with the outputs.
module tb_rtc_timekeeper;
  localparam int TPS = 4;
  localparam int SW  = 2;

  logic kh_clk = 1'b0;
  logic reset;
  always #5 kh_clk = ~kh_clk;

  rtc_timekeeper_if #(.SUB_W(SW)) bus ();

  rtc_timekeeper #(.TICKS_PER_SEC(TPS), .SUB_W(SW)) dut (
    .kh_clk (kh_clk),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct {
    string         nm;
    logic [4:0]    hr;
    logic [5:0]    mi;
    logic [5:0]    se;
    logic [SW-1:0] sb;
    logic [4:0]    dh;
    logic          pm, sp, mp, dp, ack, err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t ex(string nm, int h, int mi, int se, int sb, int dh, int pm,
                              int sp, int mp, int dp, int ack, int err);
    exp_t e;
    e.nm = nm;  e.hr = 5'(h); e.mi = 6'(mi); e.se = 6'(se); e.sb = SW'(sb);
    e.dh = 5'(dh); e.pm = 1'(pm); e.sp = 1'(sp); e.mp = 1'(mp); e.dp = 1'(dp);
    e.ack = 1'(ack); e.err = 1'(err);
    return e;
  endfunction

  function automatic void compare(exp_t e);
    logic ok;
    ok = (bus.hr === e.hr) && (bus.min === e.mi) && (bus.sec === e.se) &&
         (bus.sub === e.sb) && (bus.disp_hr === e.dh) && (bus.pm === e.pm) &&
         (bus.sec_pulse === e.sp) && (bus.min_pulse === e.mp) &&
         (bus.day_pulse === e.dp) && (bus.set_ack === e.ack) &&
         (bus.set_err === e.err) && (bus.disp_time === {e.dh, e.mi, e.se, e.sb});
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d:%0d:%0d.%0d disp=%0d pm=%b pulses=%b%b%b ack=%b err=%b dt=%h; want %0d:%0d:%0d.%0d disp=%0d pm=%b pulses=%b%b%b ack=%b err=%b",
               e.nm, bus.hr, bus.min, bus.sec, bus.sub, bus.disp_hr, bus.pm,
               bus.sec_pulse, bus.min_pulse, bus.day_pulse, bus.set_ack, bus.set_err,
               bus.disp_time, e.hr, e.mi, e.se, e.sb, e.dh, e.pm, e.sp, e.mp, e.dp,
               e.ack, e.err);
    end
  endfunction

  task automatic drv(input logic run, input logic m12, input logic sv,
                     input int sh, input int sm, input int ss,
                     input logic fw, input logic bk, input exp_t e);
    @(negedge kh_clk);
    bus.run_en    = run;
    bus.mode_12h  = m12;
    bus.set_valid = sv;
    bus.set_hr    = 5'(sh);
    bus.set_min   = 6'(sm);
    bus.set_sec   = 6'(ss);
    bus.dst_fwd   = fw;
    bus.dst_back  = bk;
    q.push_back(e);
  endtask

  // Monitor: one expected entry per driven cycle, checked after the edge.
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge kh_clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        compare(e);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset         = 1'b1;
    bus.run_en    = 1'b0;
    bus.mode_12h  = 1'b1;
    bus.set_valid = 1'b0;
    bus.set_hr    = '0;
    bus.set_min   = '0;
    bus.set_sec   = '0;
    bus.dst_fwd   = 1'b0;
    bus.dst_back  = 1'b0;

    // Reset state in both display modes
    repeat (2) @(negedge kh_clk);
    compare(ex("reset_12h", 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0));
    bus.mode_12h = 1'b0;
    @(negedge kh_clk);
    compare(ex("reset_24h", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // First second: sub 1,2,3,0 with sec_pulse only on the wrap
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("run1", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("run2", 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("run3", 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("run4", 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));

    // Midnight rollover
    drv(1, 0, 1, 23, 59, 59, 0, 0, ex("load_235959", 23, 59, 59, 0, 23, 1, 0, 0, 0, 1, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("pre_mid1", 23, 59, 59, 1, 23, 1, 0, 0, 0, 0, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("pre_mid2", 23, 59, 59, 2, 23, 1, 0, 0, 0, 0, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("pre_mid3", 23, 59, 59, 3, 23, 1, 0, 0, 0, 0, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("midnight", 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));

    // Rejected and accepted loads; rejected load does not block DST
    drv(1, 0, 1, 24, 0, 0, 0, 0, ex("bad_hr", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    drv(1, 0, 1, 12, 30, 45, 0, 0, ex("load_123045", 12, 30, 45, 0, 12, 1, 0, 0, 0, 1, 0));
    drv(1, 0, 1, 12, 60, 0, 1, 0, ex("bad_min_dst", 13, 30, 45, 1, 13, 1, 0, 0, 0, 0, 1));

    // DST wraps while held, both requests cancel
    drv(0, 0, 1, 23, 10, 0, 0, 0, ex("load_231000", 23, 10, 0, 0, 23, 1, 0, 0, 0, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 1, 0, ex("dst_fwd_wrap", 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 1, ex("dst_back_wrap", 23, 10, 0, 0, 23, 1, 0, 0, 0, 0, 0));
    drv(0, 0, 0, 0, 0, 0, 1, 1, ex("dst_both", 23, 10, 0, 0, 23, 1, 0, 0, 0, 0, 0));

    // DST on top of an hour carry in the same cycle: 22->23 then +1 -> 0
    drv(1, 0, 1, 22, 59, 59, 0, 0, ex("load_225959", 22, 59, 59, 0, 22, 1, 0, 0, 0, 1, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("hc1", 22, 59, 59, 1, 22, 1, 0, 0, 0, 0, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("hc2", 22, 59, 59, 2, 22, 1, 0, 0, 0, 0, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("hc3", 22, 59, 59, 3, 22, 1, 0, 0, 0, 0, 0));
    drv(1, 0, 0, 0, 0, 0, 1, 0, ex("carry_dst", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

    // 12 h display decode
    drv(0, 1, 1, 0, 0, 0, 0, 0, ex("m12_h0", 0, 0, 0, 0, 12, 0, 0, 0, 0, 1, 0));
    drv(0, 1, 1, 11, 0, 0, 0, 0, ex("m12_h11", 11, 0, 0, 0, 11, 0, 0, 0, 0, 1, 0));
    drv(0, 1, 1, 12, 0, 0, 0, 0, ex("m12_h12", 12, 0, 0, 0, 12, 1, 0, 0, 0, 1, 0));
    drv(0, 1, 1, 13, 0, 0, 0, 0, ex("m12_h13", 13, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 0, ex("m24_h13", 13, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0));

    // Valid load discards same-cycle DST, then count to 05:17:33.2
    drv(1, 0, 1, 5, 17, 33, 1, 0, ex("load_dst_ignored", 5, 17, 33, 0, 5, 0, 0, 0, 0, 1, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("pre_rst1", 5, 17, 33, 1, 5, 0, 0, 0, 0, 0, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("pre_rst2", 5, 17, 33, 2, 5, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset between edges
    @(negedge kh_clk);
    #2;
    reset = 1'b1;
    #1;
    compare(ex("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.run_en = 1'b0;
    repeat (2) @(negedge kh_clk);
    reset = 1'b0;
    drv(1, 0, 0, 0, 0, 0, 0, 0, ex("after_reset", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge kh_clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
